// File: rtl/mem_stage.sv
// MIPS MEM stage: byte-addressed data memory with sized loads/stores,
// branch resolution toward fetch, and the MEM/WB pipeline register.
module mem_stage #(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_zero,
    input  logic        in_branch,
    input  logic        in_RegWrite,
    input  logic        in_MemWrite,
    input  logic        in_MemRead,
    input  logic        in_MemToReg,
    input  logic [1:0]  in_load_mode,
    input  logic [4:0]  in_writebackDestination,
    input  logic [31:0] in_aluResult,
    input  logic [31:0] in_rt,
    input  logic [31:0] in_pc,
    input  logic        stall,
    input  logic        flush,
    output logic        pc_src_out,
    output logic [31:0] branch_target_out,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic [31:0] mem_data_out,
    output logic [31:0] aluResult_out,
    output logic [4:0]  writebackDestination_out
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEST_W = 5;

    logic [DATA_W-1:0]    mem_q [MEM_WORDS];
    logic [ADDR_BITS-1:0] word_idx_c;
    logic [DATA_W-1:0]    rd_word_c;
    logic [DATA_W-1:0]    load_c;
    logic [DATA_W-1:0]    wr_word_c;
    logic [DATA_W-1:0]    wr_data_c;
    logic [3:0]           wr_be_c;
    logic                 wr_en_c;
    logic [15:0]          half_c;
    logic [7:0]           byte_c;

    logic              regwrite_q, regwrite_d;
    logic              memtoreg_q, memtoreg_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DEST_W-1:0] dest_q, dest_d;

    // Branch resolution is purely combinational and ignores stall/flush.
    assign pc_src_out        = in_branch & in_zero;
    assign branch_target_out = in_pc;

    // Word index wraps modulo the memory size; read is asynchronous.
    assign word_idx_c = in_aluResult[ADDR_BITS+1:2];
    assign rd_word_c  = mem_q[word_idx_c];

    // Lane selection and sign/zero extension of the load data.
    always_comb begin
        load_c = '0;
        half_c = in_aluResult[1] ? rd_word_c[31:16] : rd_word_c[15:0];
        byte_c = rd_word_c[{in_aluResult[1:0], 3'b000} +: 8];
        if (in_MemRead) begin
            case (in_load_mode)
                2'b00:   load_c = rd_word_c;
                2'b01:   load_c = {{16{half_c[15]}}, half_c};
                2'b10:   load_c = {{24{byte_c[7]}}, byte_c};
                default: load_c = {24'h0, byte_c};
            endcase
        end
    end

    // Store merge: replicate data across lanes, then enable only the target lanes.
    always_comb begin
        wr_en_c   = in_MemWrite & ~stall & rst_n;
        wr_be_c   = 4'b1111;
        wr_data_c = in_rt;
        case (in_load_mode)
            2'b00: begin
                wr_be_c   = 4'b1111;
                wr_data_c = in_rt;
            end
            2'b01: begin
                wr_be_c   = in_aluResult[1] ? 4'b1100 : 4'b0011;
                wr_data_c = {2{in_rt[15:0]}};
            end
            default: begin
                wr_be_c   = 4'(4'b0001 << in_aluResult[1:0]);
                wr_data_c = {4{in_rt[7:0]}};
            end
        endcase
        wr_word_c = rd_word_c;
        for (int k = 0; k < 4; k++) begin
            if (wr_be_c[k]) begin
                wr_word_c[8*k +: 8] = wr_data_c[8*k +: 8];
            end
        end
    end

    // Data memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[word_idx_c] <= wr_word_c;
        end
    end

    // MEM/WB next state: stall holds, flush kills control bits only.
    always_comb begin
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        mem_data_d = mem_data_q;
        alu_d      = alu_q;
        dest_d     = dest_q;
        if (!stall) begin
            regwrite_d = in_RegWrite & ~flush;
            memtoreg_d = in_MemToReg & ~flush;
            mem_data_d = load_c;
            alu_d      = in_aluResult;
            dest_d     = in_writebackDestination;
        end
    end

    // MEM/WB register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            mem_data_q <= '0;
            alu_q      <= '0;
            dest_q     <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            mem_data_q <= mem_data_d;
            alu_q      <= alu_d;
            dest_q     <= dest_d;
        end
    end

    assign RegWrite_out             = regwrite_q;
    assign MemToReg_out             = memtoreg_q;
    assign mem_data_out             = mem_data_q;
    assign aluResult_out            = alu_q;
    assign writebackDestination_out = dest_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized traffic
// checked against a word-array reference model of the stage.
module tb_mem_stage;

    localparam int unsigned MEM_WORDS = 256;
    localparam int unsigned ADDR_BITS = 8;

    logic        clk;
    logic        rst_n;
    logic        in_zero, in_branch, in_RegWrite, in_MemWrite, in_MemRead, in_MemToReg;
    logic [1:0]  in_load_mode;
    logic [4:0]  in_writebackDestination;
    logic [31:0] in_aluResult, in_rt, in_pc;
    logic        stall, flush;
    logic        pc_src_out;
    logic [31:0] branch_target_out;
    logic        RegWrite_out, MemToReg_out;
    logic [31:0] mem_data_out, aluResult_out;
    logic [4:0]  writebackDestination_out;

    mem_stage #(.MEM_WORDS(MEM_WORDS), .ADDR_BITS(ADDR_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .in_zero(in_zero), .in_branch(in_branch),
        .in_RegWrite(in_RegWrite), .in_MemWrite(in_MemWrite), .in_MemRead(in_MemRead),
        .in_MemToReg(in_MemToReg), .in_load_mode(in_load_mode),
        .in_writebackDestination(in_writebackDestination), .in_aluResult(in_aluResult),
        .in_rt(in_rt), .in_pc(in_pc), .stall(stall), .flush(flush),
        .pc_src_out(pc_src_out), .branch_target_out(branch_target_out),
        .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
        .mem_data_out(mem_data_out), .aluResult_out(aluResult_out),
        .writebackDestination_out(writebackDestination_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] mem_m [MEM_WORDS];
    logic        exp_rw, exp_m2r;
    logic [31:0] exp_data, exp_alu;
    logic [4:0]  exp_dest;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [31:0] ld_fn(input logic [31:0] w, input logic [1:0] mode,
                                          input logic [1:0] off);
        int unsigned v;
        int unsigned sh;
        case (mode)
            2'd0: return w;
            2'd1: begin
                sh = off[1] ? 16 : 0;
                v  = (w >> sh) & 32'hFFFF;
                return (v >= 32'h8000) ? 32'(v + 32'hFFFF0000) : 32'(v);
            end
            2'd2: begin
                sh = 8 * int'(off);
                v  = (w >> sh) & 32'hFF;
                return (v >= 32'h80) ? 32'(v + 32'hFFFFFF00) : 32'(v);
            end
            default: begin
                sh = 8 * int'(off);
                return (w >> sh) & 32'hFF;
            end
        endcase
    endfunction

    function automatic logic [31:0] st_fn(input logic [31:0] w, input logic [31:0] rt,
                                          input logic [1:0] mode, input logic [1:0] off);
        logic [31:0] mask;
        int unsigned sh;
        case (mode)
            2'd0: begin sh = 0; mask = 32'hFFFFFFFF; end
            2'd1: begin sh = off[1] ? 16 : 0; mask = 32'hFFFF << sh; end
            default: begin sh = 8 * int'(off); mask = 32'hFF << sh; end
        endcase
        return (w & ~mask) | ((rt << sh) & mask);
    endfunction

    // Advance the model by one clock edge using the currently applied inputs.
    task automatic model_step();
        int unsigned wi;
        wi = (in_aluResult >> 2) % MEM_WORDS;
        if (!rst_n) begin
            exp_rw = 0; exp_m2r = 0; exp_data = 0; exp_alu = 0; exp_dest = 0;
        end else if (!stall) begin
            exp_data = in_MemRead ? ld_fn(mem_m[wi], in_load_mode, in_aluResult[1:0]) : 32'h0;
            exp_rw   = in_RegWrite && !flush;
            exp_m2r  = in_MemToReg && !flush;
            exp_alu  = in_aluResult;
            exp_dest = in_writebackDestination;
            if (in_MemWrite) mem_m[wi] = st_fn(mem_m[wi], in_rt, in_load_mode, in_aluResult[1:0]);
        end
    endtask

    // Registered outputs compared against the model after every edge.
    always @(negedge clk) begin
        check("RegWrite_out", 32'(RegWrite_out), 32'(exp_rw));
        check("MemToReg_out", 32'(MemToReg_out), 32'(exp_m2r));
        check("mem_data_out", mem_data_out, exp_data);
        check("aluResult_out", aluResult_out, exp_alu);
        check("wb_dest_out", 32'(writebackDestination_out), 32'(exp_dest));
    end

    // Apply current inputs for one clock; returns just after the falling edge.
    task automatic cycle();
        #1;
        check("pc_src_out", 32'(pc_src_out), 32'(in_branch & in_zero));
        check("branch_target_out", branch_target_out, in_pc);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        rst_n = 1; in_zero = 0; in_branch = 0; in_RegWrite = 0; in_MemWrite = 0;
        in_MemRead = 0; in_MemToReg = 0; in_load_mode = 0; in_writebackDestination = 0;
        in_aluResult = 0; in_rt = 0; in_pc = 0; stall = 0; flush = 0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
        clr(); in_MemWrite = 1; in_aluResult = a; in_rt = d; in_load_mode = m; cycle();
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] m);
        clr(); in_MemRead = 1; in_aluResult = a; in_load_mode = m; cycle();
    endtask

    initial begin
        clr();
        rst_n = 0;
        cycle();
        check("reset_rw", 32'(RegWrite_out), 32'h0);
        check("reset_data", mem_data_out, 32'h0);

        // Give every word a known value
        for (int w = 0; w < int'(MEM_WORDS); w++) store(32'(w * 4), $urandom, 2'd0);

        // Reset blocks stores and clears outputs
        store(32'h50, 32'h600D600D, 2'd0);
        clr(); rst_n = 0; in_RegWrite = 1; in_MemWrite = 1; in_MemRead = 1; in_MemToReg = 1;
        in_aluResult = 32'h50; in_rt = 32'hFFFFFFFF; in_writebackDestination = 5'd31;
        cycle(); cycle();
        check("rst_rw", 32'(RegWrite_out), 32'h0);
        check("rst_m2r", 32'(MemToReg_out), 32'h0);
        check("rst_alu", aluResult_out, 32'h0);
        check("rst_dest", 32'(writebackDestination_out), 32'h0);
        load(32'h50, 2'd0);
        check("rst_mem_kept", mem_data_out, 32'h600D600D);

        // Word store, unaligned-address word load
        store(32'h10, 32'hDEADBEEF, 2'd0);
        load(32'h13, 2'd0);
        check("word_load", mem_data_out, 32'hDEADBEEF);

        // Sized loads
        store(32'h20, 32'h8000FF7F, 2'd0);
        load(32'h20, 2'd2); check("lb_off0", mem_data_out, 32'h0000007F);
        load(32'h21, 2'd2); check("lb_off1", mem_data_out, 32'hFFFFFFFF);
        load(32'h21, 2'd3); check("lbu_off1", mem_data_out, 32'h000000FF);
        load(32'h22, 2'd1); check("lh_off2", mem_data_out, 32'hFFFF8000);

        // Sized stores
        store(32'h30, 32'h11223344, 2'd0);
        store(32'h32, 32'h000000AA, 2'd2);
        load(32'h30, 2'd0); check("sb_merge", mem_data_out, 32'h11AA3344);
        store(32'h30, 32'h0000BEEF, 2'd1);
        load(32'h30, 2'd0); check("sh_merge", mem_data_out, 32'h11AABEEF);

        // Address wrap and same-cycle read/write
        store(32'(MEM_WORDS * 4 + 4), 32'h12345678, 2'd0);
        load(32'h4, 2'd0); check("wrap", mem_data_out, 32'h12345678);
        clr(); in_MemRead = 1; in_MemWrite = 1; in_aluResult = 32'h4; in_rt = 32'hCAFEF00D;
        cycle(); check("rw_old", mem_data_out, 32'h12345678);
        load(32'h4, 2'd0); check("rw_new", mem_data_out, 32'hCAFEF00D);

        // Branch resolution
        clr(); in_branch = 1; in_zero = 1; in_pc = 32'h00401234; #1;
        check("br_taken", 32'(pc_src_out), 32'h1);
        check("br_target", branch_target_out, 32'h00401234);
        cycle();
        clr(); in_branch = 1; in_zero = 0; #1;
        check("br_not_taken", 32'(pc_src_out), 32'h0);
        cycle();

        // Stall holds outputs and blocks the store
        store(32'h40, 32'h0BADF00D, 2'd0);
        clr(); in_RegWrite = 1; in_MemToReg = 1; in_writebackDestination = 5'd7;
        in_aluResult = 32'h44; cycle();
        clr(); stall = 1; in_MemWrite = 1; in_aluResult = 32'h40; in_rt = 32'h55;
        in_writebackDestination = 5'd3; cycle();
        check("stall_rw", 32'(RegWrite_out), 32'h1);
        check("stall_dest", 32'(writebackDestination_out), 32'h7);
        check("stall_alu", aluResult_out, 32'h44);
        load(32'h40, 2'd0); check("stall_no_store", mem_data_out, 32'h0BADF00D);

        // Flush kills control only
        clr(); flush = 1; in_RegWrite = 1; in_MemToReg = 1; in_writebackDestination = 5'd9;
        in_aluResult = 32'h99; cycle();
        check("flush_rw", 32'(RegWrite_out), 32'h0);
        check("flush_alu", aluResult_out, 32'h99);

        // Stall beats flush
        clr(); in_RegWrite = 1; in_writebackDestination = 5'd5; cycle();
        clr(); stall = 1; flush = 1; in_writebackDestination = 5'd6; cycle();
        check("stall_flush_rw", 32'(RegWrite_out), 32'h1);
        check("stall_flush_dest", 32'(writebackDestination_out), 32'h5);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n        = ($urandom_range(0, 31) != 0);
            in_zero      = 1'($urandom);
            in_branch    = 1'($urandom);
            in_RegWrite  = 1'($urandom);
            in_MemWrite  = ($urandom_range(0, 2) == 0);
            in_MemRead   = ($urandom_range(0, 1) == 0);
            in_MemToReg  = 1'($urandom);
            in_load_mode = 2'($urandom);
            in_writebackDestination = 5'($urandom);
            in_aluResult = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
            in_rt        = $urandom;
            in_pc        = $urandom;
            stall        = ($urandom_range(0, 7) == 0);
            flush        = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
